wb_regfile: RTL

Writeback stage and architectural register file of the rv32i pipeline: the consumer end of the MEM/WB pipeline register. Selects the writeback value from the MEM/WB outputs, commits it to the 32×32 register file, and serves two combinational read ports to ID with same-cycle write-to-read bypass. Also exposes the selected writeback value for EX forwarding and maintains a 64-bit retired-instruction counter.

---
 rtl/rv32i_pkg.sv | 20 ++
 rtl/rf_array.sv | 33 +++
 rtl/wb_regfile.sv | 81 ++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared rv32i constants: datapath width, register address width, writeback source encodings.
// No logic, no latency, no backpressure.
package rv32i_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        WB_SEL_ALU = 2'b00,
        WB_SEL_DM  = 2'b01,
        WB_SEL_PC  = 2'b10,
        WB_SEL_RSV = 2'b11
    } wb_sel_e;

    // Reserved encoding carries no data and must never reach the register file.
    function automatic logic wb_sel_is_valid(input logic [1:0] sel);
        return sel != WB_SEL_RSV;
    endfunction

endpackage

// File: rtl/rf_array.sv
// x1..x31 storage with one write port and two raw combinational read ports (address 0 reads 0).
// Latency: write lands on the next posedge, reads are zero-cycle; no backpressure.
module rf_array
    import rv32i_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [XLEN-1:0]       wdata,
    input  logic [REG_ADDR_W-1:0] raddr1,
    input  logic [REG_ADDR_W-1:0] raddr2,
    output logic [XLEN-1:0]       rdata1,
    output logic [XLEN-1:0]       rdata2
);

    // x0 has no storage; index 0 is guarded on both read and write.
    logic [XLEN-1:0] regs [31:1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/wb_regfile.sv
// Writeback select, register-file commit, bypassed ID read ports and retired-instruction counter.
// Latency: reads/wb_data/wb_commit combinational, writes and instret on posedge; enable low stalls everything.
module wb_regfile
    import rv32i_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  wb_valid,
    input  logic [1:0]            wb_rf_din_sel,
    input  logic [XLEN-1:0]       wb_dm_dout,
    input  logic [XLEN-1:0]       wb_alu_dout,
    input  logic [XLEN-1:0]       wb_pc_next,
    input  logic                  wb_rf_we,
    input  logic [REG_ADDR_W-1:0] wb_rf_waddr,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    output logic [XLEN-1:0]       id_rs1_data,
    output logic [XLEN-1:0]       id_rs2_data,
    output logic [XLEN-1:0]       wb_data,
    output logic                  wb_commit,
    output logic [63:0]           instret
);

    logic [XLEN-1:0] raw_rs1;
    logic [XLEN-1:0] raw_rs2;
    logic [63:0]     instret_q;

    always_comb begin
        wb_data = '0;
        case (wb_sel_e'(wb_rf_din_sel))
            WB_SEL_ALU: wb_data = wb_alu_dout;
            WB_SEL_DM:  wb_data = wb_dm_dout;
            WB_SEL_PC:  wb_data = wb_pc_next;
            default:    wb_data = '0;
        endcase
    end

    assign wb_commit = enable & wb_valid & wb_rf_we & (wb_rf_waddr != '0)
                     & wb_sel_is_valid(wb_rf_din_sel);

    rf_array u_rf_array (
        .clk    (clk),
        .rst    (rst),
        .we     (wb_commit),
        .waddr  (wb_rf_waddr),
        .wdata  (wb_data),
        .raddr1 (id_rs1_addr),
        .raddr2 (id_rs2_addr),
        .rdata1 (raw_rs1),
        .rdata2 (raw_rs2)
    );

    // Same-cycle bypass; x0 check first so a bypass can never leak into x0.
    always_comb begin
        id_rs1_data = raw_rs1;
        id_rs2_data = raw_rs2;
        if (id_rs1_addr == '0) begin
            id_rs1_data = '0;
        end else if (wb_commit && (id_rs1_addr == wb_rf_waddr)) begin
            id_rs1_data = wb_data;
        end
        if (id_rs2_addr == '0) begin
            id_rs2_data = '0;
        end else if (wb_commit && (id_rs2_addr == wb_rf_waddr)) begin
            id_rs2_data = wb_data;
        end
    end

    // Every retired instruction counts, including stores and branches with no rd write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_q <= '0;
        end else if (enable && wb_valid) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign instret = instret_q;

endmodule
